// File: rtl/routing_header_demux_pkg.sv
// Shared definitions for the routing-header demux slice.
//   - fifo36 line layout: [35:34] occupancy, [33] EOF, [32] SOF, [31:0] data
//   - routing header layout: [31:28] magic, [18:17] port_sel, [16] route bit,
//     [15:2] payload word count (flags line included)
//   - demux frame-tracking state encoding
package routing_header_demux_pkg;

  localparam int unsigned F36_W      = 36;
  localparam int unsigned F36_OCC_HI = 35;
  localparam int unsigned F36_OCC_LO = 34;
  localparam int unsigned F36_EOF    = 33;
  localparam int unsigned F36_SOF    = 32;

  localparam logic [3:0]  HDR_MAGIC     = 4'b0001;
  localparam int unsigned HDR_MAGIC_HI  = 31;
  localparam int unsigned HDR_MAGIC_LO  = 28;
  localparam int unsigned HDR_SEL_HI    = 18;
  localparam int unsigned HDR_SEL_LO    = 17;
  localparam int unsigned HDR_ROUTE_BIT = 16;
  localparam int unsigned HDR_LEN_HI    = 15;
  localparam int unsigned HDR_LEN_LO    = 2;
  localparam int unsigned LEN_W         = 14;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_FLAGS,
    ST_PAYLOAD,
    ST_DROP
  } demux_state_t;

endpackage

// File: rtl/routing_hdr_decode.sv
// Combinational routing header decoder.
//   line     : fifo36 line presented as a candidate header
//   magic_ok : [31:28] carries the header magic
//   port_sel : requested output port
//   len      : declared payload word count (flags line included)
//   valid    : header may be routed (magic ok, route bit set, port exists,
//              and the header is not also the last line of its frame)
module routing_hdr_decode
  import routing_header_demux_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [F36_W-1:0] line,
  output logic             magic_ok,
  output logic [1:0]       port_sel,
  output logic [LEN_W-1:0] len,
  output logic             valid
);

  logic port_ok;
  logic unused_bits;

  always_comb begin
    magic_ok = (line[HDR_MAGIC_HI:HDR_MAGIC_LO] == HDR_MAGIC);
    port_sel = line[HDR_SEL_HI:HDR_SEL_LO];
    len      = line[HDR_LEN_HI:HDR_LEN_LO];
    port_ok  = (32'(port_sel) < NUM_PORTS);
    valid    = magic_ok && line[HDR_ROUTE_BIT] && port_ok && !line[F36_EOF];
  end

  assign unused_bits = ^{line[F36_OCC_HI:F36_OCC_LO], line[F36_SOF],
                         line[27:19], line[1:0]};

endmodule

// File: rtl/routing_header_demux.sv
// Routing header demux: strips the routing header (and the flags line when
// STRIP_FLAGS=1) from each fifo36 frame and steers the payload to the port
// named in the header. Datapath is combinational, zero latency.
//   clk, reset, clear : clock, synchronous active-high reset / clear
//   data_i, src_rdy_i, dst_rdy_o : fifo36 input side
//   data_o, src_rdy_o[NUM_PORTS], dst_rdy_i[NUM_PORTS] : per-port outputs
//   flags_o   : flags word latched from the current frame
//   bad_hdr_o : one-cycle pulse when a frame is discarded
//   len_err_o : one-cycle pulse on length mismatch
// Build option: ROUTE_HDR_LEN_CHECK_EN enables the payload length checker;
// without it len_err_o is tied low.
module routing_header_demux
  import routing_header_demux_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter bit          STRIP_FLAGS = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [F36_W-1:0]     data_i,
  input  logic                 src_rdy_i,
  output logic                 dst_rdy_o,
  output logic [F36_W-1:0]     data_o,
  output logic [NUM_PORTS-1:0] src_rdy_o,
  input  logic [NUM_PORTS-1:0] dst_rdy_i,
  output logic [31:0]          flags_o,
  output logic                 bad_hdr_o,
  output logic                 len_err_o
);

  demux_state_t     state, state_nxt;
  logic [1:0]       sel_q;
  logic             first_q;
  logic [31:0]      flags_q;
  logic             bad_hdr_q, bad_hdr_d;
  logic             latch_hdr, latch_flags;
  logic             in_xfer, eof;

  logic             hdr_magic_ok;
  logic [1:0]       hdr_port_sel;
  logic [LEN_W-1:0] hdr_len;
  logic             hdr_valid;

  routing_hdr_decode #(
    .NUM_PORTS(NUM_PORTS)
  ) u_decode (
    .line     (data_i),
    .magic_ok (hdr_magic_ok),
    .port_sel (hdr_port_sel),
    .len      (hdr_len),
    .valid    (hdr_valid)
  );

  assign eof     = data_i[F36_EOF];
  assign in_xfer = src_rdy_i && dst_rdy_o;

  always_comb begin
    state_nxt   = state;
    dst_rdy_o   = 1'b1;
    src_rdy_o   = '0;
    data_o      = data_i;
    bad_hdr_d   = 1'b0;
    latch_hdr   = 1'b0;
    latch_flags = 1'b0;
    case (state)
      ST_HDR: begin
        if (src_rdy_i) begin
          latch_hdr = 1'b1;
          if (eof) begin
            bad_hdr_d = 1'b1;
          end else if (hdr_valid) begin
            state_nxt = STRIP_FLAGS ? ST_FLAGS : ST_PAYLOAD;
          end else begin
            bad_hdr_d = 1'b1;
            state_nxt = ST_DROP;
          end
        end
      end
      ST_FLAGS: begin
        if (src_rdy_i) begin
          latch_flags = 1'b1;
          if (eof) begin
            bad_hdr_d = 1'b1;
            state_nxt = ST_HDR;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        dst_rdy_o       = 1'b0;
        data_o[F36_SOF] = first_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (32'(sel_q) == p) begin
            dst_rdy_o    = dst_rdy_i[p];
            src_rdy_o[p] = src_rdy_i;
          end
        end
        if (src_rdy_i && dst_rdy_o && eof) state_nxt = ST_HDR;
      end
      ST_DROP: begin
        if (src_rdy_i && eof) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // first_q is held set outside PAYLOAD so the first emitted line always
  // carries SOF, regardless of how the frame entered PAYLOAD.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= ST_HDR;
      sel_q     <= '0;
      first_q   <= 1'b1;
      flags_q   <= '0;
      bad_hdr_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bad_hdr_q <= bad_hdr_d;
      if (latch_hdr) sel_q <= hdr_port_sel;
      if (state != ST_PAYLOAD) first_q <= 1'b1;
      else if (in_xfer)        first_q <= 1'b0;
      if (latch_flags) flags_q <= data_i[31:0];
    end
  end

  assign flags_o   = flags_q;
  assign bad_hdr_o = bad_hdr_q;

`ifdef ROUTE_HDR_LEN_CHECK_EN
  logic [LEN_W-1:0] len_q, cnt_q, cnt_inc;
  logic             len_err_q;
  logic             unused_dec;

  // Count includes the line being accepted, so the EOF line compares
  // against the complete post-header word count.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (latch_hdr) len_q <= hdr_len;
      if (state == ST_HDR)
        cnt_q <= '0;
      else if ((state == ST_FLAGS || state == ST_PAYLOAD) && in_xfer)
        cnt_q <= cnt_inc;
      len_err_q <= (state == ST_PAYLOAD) && in_xfer && eof && (cnt_inc != len_q);
    end
  end

  assign len_err_o  = len_err_q;
  assign unused_dec = hdr_magic_ok;
`else
  logic unused_dec;
  assign len_err_o  = 1'b0;
  assign unused_dec = ^{hdr_len, hdr_magic_ok};
`endif

endmodule

// File: tb/tb_routing_header_demux.sv
module tb_routing_header_demux;

  localparam int unsigned NP = 3;

  logic          clk;
  logic          reset;
  logic          clear;
  logic [35:0]   data_i;
  logic          src_rdy_i;
  logic          dst_rdy_o;
  logic [35:0]   data_o;
  logic [NP-1:0] src_rdy_o;
  logic [NP-1:0] dst_rdy_i;
  logic [31:0]   flags_o;
  logic          bad_hdr_o;
  logic          len_err_o;

  routing_header_demux #(
    .NUM_PORTS   (NP),
    .STRIP_FLAGS (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .data_i    (data_i),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .data_o    (data_o),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i),
    .flags_o   (flags_o),
    .bad_hdr_o (bad_hdr_o),
    .len_err_o (len_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // monitor results
  logic [35:0] out_q[$];
  int          port_q[$];
  int          bad_cnt = 0;
  int          len_cnt = 0;
  int          multi_hot = 0;
  bit          rnd_rdy = 0;

  // reference model results
  logic [35:0] cur_frame[$];
  logic [35:0] exp_q[$];
  int          exp_port_q[$];
  int          exp_bad = 0;
  int          exp_len = 0;
  logic [31:0] exp_flags = '0;
  bit          exp_deliver = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !clear) begin
        if ($countones(src_rdy_o) > 1) multi_hot++;
        for (int p = 0; p < NP; p++) begin
          if (src_rdy_o[p] && dst_rdy_i[p]) begin
            out_q.push_back(data_o);
            port_q.push_back(p);
          end
        end
        if (bad_hdr_o) bad_cnt++;
        if (len_err_o) len_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) dst_rdy_i = NP'($urandom);
    end
  end

  function automatic logic [35:0] mk_hdr(input logic [3:0] magic, input logic [1:0] sel,
                                         input logic rb, input logic [13:0] n, input logic eof);
    return {2'b00, eof, 1'b1, magic, 9'h000, sel, rb, n, 2'b00};
  endfunction

  function automatic logic [35:0] mk_line(input logic eof, input logic [31:0] d);
    logic [1:0] occ;
    logic       sof;
    occ = 2'($urandom);
    sof = 1'($urandom);
    return {occ, eof, sof, d};
  endfunction

  task automatic build_frame(input logic [1:0] sel, input logic [3:0] magic, input logic rb,
                             input int nlines, input int nfield);
    cur_frame.delete();
    cur_frame.push_back(mk_hdr(magic, sel, rb, 14'(nfield), nlines == 1));
    for (int i = 1; i < nlines; i++) cur_frame.push_back(mk_line(i == nlines - 1, $urandom));
  endtask

  // Frame-level behaviour: a routable header with a flags line and at least
  // one payload line delivers lines 2..n-1 to the selected port, SOF set only
  // on the first; everything else is a single discard event.
  task automatic model_frame();
    logic [35:0] hdr, l;
    int          n;
    hdr = cur_frame[0];
    n   = cur_frame.size();
    if (n == 1) begin
      exp_bad++;
    end else if (!(hdr[31:28] == 4'b0001 && hdr[16] && int'(hdr[18:17]) < NP)) begin
      exp_bad++;
    end else if (n == 2) begin
      exp_bad++;
    end else begin
      exp_deliver = 1;
      l = cur_frame[1];
      exp_flags = l[31:0];
      for (int i = 2; i < n; i++) begin
        l = cur_frame[i];
        l[32] = (i == 2);
        exp_q.push_back(l);
        exp_port_q.push_back(int'(hdr[18:17]));
      end
`ifdef ROUTE_HDR_LEN_CHECK_EN
      if (n - 1 != int'(hdr[15:2])) exp_len++;
`endif
    end
  endtask

  task automatic send_line(input logic [35:0] l, input int gap, output int cyc);
    bit acc;
    cyc = 0;
    for (int g = 0; g < gap; g++) begin
      src_rdy_i = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    data_i    = l;
    src_rdy_i = 1'b1;
    acc       = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = dst_rdy_o;
      @(posedge clk); #1;
      cyc++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_line_timeout: dst_rdy_o=0 for 200 cycles, required 1");
    end
  endtask

  task automatic send_frame(input int gap_max, output int cyc);
    int c;
    cyc = 0;
    foreach (cur_frame[i]) begin
      send_line(cur_frame[i], $urandom_range(gap_max, 0), c);
      cyc += c;
    end
  endtask

  task automatic clear_scoreboard();
    out_q.delete(); port_q.delete();
    bad_cnt = 0; len_cnt = 0; multi_hot = 0;
    exp_q.delete(); exp_port_q.delete();
    exp_bad = 0; exp_len = 0; exp_deliver = 0;
  endtask

  task automatic check_frame(input string name);
    int m;
    src_rdy_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    tests++;
    if (out_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d lines, expected %0d", name, out_q.size(), exp_q.size());
    end
    m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      tests++;
      if (out_q[i] !== exp_q[i] || port_q[i] != exp_port_q[i]) begin
        fails++;
        $display("FAIL %s_line%0d: got %h on port %0d, expected %h on port %0d",
                 name, i, out_q[i], port_q[i], exp_q[i], exp_port_q[i]);
      end
    end
    tests++;
    if (bad_cnt != exp_bad) begin
      fails++;
      $display("FAIL %s_bad_hdr: got %0d pulses, expected %0d", name, bad_cnt, exp_bad);
    end
    tests++;
    if (len_cnt != exp_len) begin
      fails++;
      $display("FAIL %s_len_err: got %0d pulses, expected %0d", name, len_cnt, exp_len);
    end
    tests++;
    if (multi_hot != 0) begin
      fails++;
      $display("FAIL %s_onehot: %0d cycles with multiple src_rdy_o, expected 0", name, multi_hot);
    end
    if (exp_deliver) begin
      tests++;
      if (flags_o !== exp_flags) begin
        fails++;
        $display("FAIL %s_flags: got %h, expected %h", name, flags_o, exp_flags);
      end
    end
    clear_scoreboard();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; src_rdy_i = 1'b0; dst_rdy_i = '1;
    data_i = 36'h9_1234_5678;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (src_rdy_o !== '0 || dst_rdy_o !== 1'b1 || flags_o !== '0 ||
        bad_hdr_o !== 1'b0 || len_err_o !== 1'b0 || data_o !== data_i) begin
      fails++;
      $display("FAIL reset_state: src_rdy_o=%b dst_rdy_o=%b flags_o=%h bad=%b len=%b data_o=%h, expected 0 1 0 0 0 %h",
               src_rdy_o, dst_rdy_o, flags_o, bad_hdr_o, len_err_o, data_o, data_i);
    end
    @(posedge clk); #1;
    clear_scoreboard();
  endtask

  task automatic test_basic();
    logic [35:0] l;
    int c;
    rnd_rdy = 0; dst_rdy_i = '1;
    build_frame(2'd2, 4'h1, 1'b1, 5, 4);
    l = cur_frame[1]; l[31:0] = 32'hA5A5_A5A5; cur_frame[1] = l;
    model_frame();
    send_frame(0, c);
    check_frame("basic");
  endtask

  task automatic test_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    tests++;
    if (flags_o !== '0) begin
      fails++;
      $display("FAIL clear_flags: got %h, expected 0", flags_o);
    end
    clear_scoreboard();
  endtask

  task automatic test_stall();
    int c;
    int stall_bad = 0;
    rnd_rdy = 0; dst_rdy_i = '1;
    build_frame(2'd2, 4'h1, 1'b1, 5, 4);
    model_frame();
    fork
      send_frame(0, c);
      begin
        for (int k = 0; k < 100 && out_q.size() < 1; k++) begin @(posedge clk); #1; end
        dst_rdy_i[2] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (dst_rdy_o !== 1'b0) stall_bad++;
          @(posedge clk); #1;
        end
        dst_rdy_i[2] = 1'b1;
      end
    join
    tests++;
    if (stall_bad != 0) begin
      fails++;
      $display("FAIL stall_dst_rdy: dst_rdy_o high in %0d of 5 stall cycles, expected 0", stall_bad);
    end
    check_frame("stall");
  endtask

  task automatic test_bad_port();
    int c;
    rnd_rdy = 1;
    build_frame(2'd3, 4'h1, 1'b1, 4, 3);
    model_frame();
    send_frame(1, c);
    check_frame("bad_port");
    rnd_rdy = 0; dst_rdy_i = '1;
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    rnd_rdy = 0; dst_rdy_i = '1;
    build_frame(2'd0, 4'h1, 1'b1, 4, 3);
    model_frame();
    send_frame(0, c1);
    build_frame(2'd1, 4'h1, 1'b1, 4, 3);
    model_frame();
    send_frame(0, c2);
    tests++;
    if (c1 + c2 != 8) begin
      fails++;
      $display("FAIL b2b_cycles: took %0d cycles for 8 lines, expected 8", c1 + c2);
    end
    check_frame("b2b");
  endtask

  task automatic test_reset_mid();
    int c;
    rnd_rdy = 0; dst_rdy_i = '1;
    build_frame(2'd1, 4'h1, 1'b1, 6, 5);
    for (int i = 0; i < 4; i++) send_line(cur_frame[i], 0, c);
    data_i = cur_frame[4]; src_rdy_i = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; src_rdy_i = 1'b0;
    @(negedge clk);
    tests++;
    if (src_rdy_o !== '0 || flags_o !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: src_rdy_o=%b flags_o=%h, expected 0 0", src_rdy_o, flags_o);
    end
    tests++;
    if (out_q.size() != 2) begin
      fails++;
      $display("FAIL reset_mid_partial: got %0d lines, expected 2", out_q.size());
    end
    @(posedge clk); #1;
    clear_scoreboard();
    build_frame(2'd0, 4'h1, 1'b1, 4, 3);
    model_frame();
    send_frame(0, c);
    check_frame("after_reset");
  endtask

  task automatic test_len_check();
    int c;
    rnd_rdy = 0; dst_rdy_i = '1;
    build_frame(2'd1, 4'h1, 1'b1, 5, 5);
    model_frame();
    send_frame(0, c);
    check_frame("len_short");
    build_frame(2'd1, 4'h1, 1'b1, 5, 4);
    model_frame();
    send_frame(0, c);
    check_frame("len_exact");
  endtask

  task automatic test_random();
    int c, r, nl, nf;
    logic [1:0] sel;
    logic [3:0] magic;
    logic rb;
    rnd_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      sel   = 2'($urandom_range(3, 0));
      magic = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 2)) : 4'h1;
      rb    = ($urandom_range(15, 0) != 0);
      r     = $urandom_range(9, 0);
      nl    = (r == 0) ? 1 : (r == 1) ? 2 : int'($urandom_range(7, 3));
      nf    = nl - 1 + (($urandom_range(3, 0) == 0) ? 1 : 0);
      build_frame(sel, magic, rb, nl, nf);
      model_frame();
      send_frame(2, c);
      check_frame("random");
    end
    rnd_rdy = 0; dst_rdy_i = '1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_stall();
    test_bad_port();
    test_back_to_back();
    test_reset_mid();
    test_len_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
